// File: rtl/hilo_mul_ctrl_if.sv
// hilo_mul_ctrl_if: pipeline-side op bus and HI/LO multiplier wrapper bus of the sequencer
interface hilo_mul_ctrl_if;
  logic        i_op_valid;
  logic [2:0]  i_op_code;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic        o_stall;
  logic [31:0] o_rd_data;
  logic        o_rd_valid;
  logic        o_err;
  logic        o_mul_start;
  logic [31:0] o_mul_opr1;
  logic [31:0] o_mul_opr2;
  logic [1:0]  o_mul_write_opt;
  logic [31:0] o_mul_write_data;
  logic [63:0] i_mul_result;
  logic        i_mul_ready;
  modport slave (
    input  i_op_valid, i_op_code, i_op_a, i_op_b, i_mul_result, i_mul_ready,
    output o_stall, o_rd_data, o_rd_valid, o_err, o_mul_start, o_mul_opr1, o_mul_opr2,
           o_mul_write_opt, o_mul_write_data
  );
  modport master (
    output i_op_valid, i_op_code, i_op_a, i_op_b, i_mul_result, i_mul_ready,
    input  o_stall, o_rd_data, o_rd_valid, o_err, o_mul_start, o_mul_opr1, o_mul_opr2,
           o_mul_write_opt, o_mul_write_data
  );
endinterface

// File: rtl/hilo_mul_ctrl.sv
// hilo_mul_ctrl: HI/LO op sequencer in front of an unsigned multiplier wrapper, signed MULT via magnitude + negated write-back
module hilo_mul_ctrl #(
  parameter bit SIGNED_EN = 1'b1,
  parameter int TIMEOUT   = 63
) (
  input logic             clk,
  input logic             rst_n,
  hilo_mul_ctrl_if.slave  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, FIX_LO, FIX_HI, WR} state_t;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_t        r_state;
  logic          r_neg;
  logic [63:0]   r_fix;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_rd_data;
  logic          r_rd_valid;
  logic          r_err;
  logic          r_mul_start;
  logic [31:0]   r_opr1;
  logic [31:0]   r_opr2;
  logic [1:0]    r_wo;
  logic [31:0]   r_wd;
  logic          w_sgn;
  logic [31:0]   w_abs_a;
  logic [31:0]   w_abs_b;
  logic [63:0]   w_neg_res;
  assign w_sgn     = SIGNED_EN && bus.i_op_code == 3'd1;
  assign w_abs_a   = (w_sgn && bus.i_op_a[31]) ? -bus.i_op_a : bus.i_op_a;
  assign w_abs_b   = (w_sgn && bus.i_op_b[31]) ? -bus.i_op_b : bus.i_op_b;
  assign w_neg_res = -bus.i_mul_result;
  assign bus.o_stall          = r_state != IDLE;
  assign bus.o_rd_data        = r_rd_data;
  assign bus.o_rd_valid       = r_rd_valid;
  assign bus.o_err            = r_err;
  assign bus.o_mul_start      = r_mul_start;
  assign bus.o_mul_opr1       = r_opr1;
  assign bus.o_mul_opr2       = r_opr2;
  assign bus.o_mul_write_opt  = r_wo;
  assign bus.o_mul_write_data = r_wd;
  // sequencer: op accept, start pulse, bounded wait, two-step negated write-back, MT* writes, MF* reads
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_neg       <= 1'b0;
      r_fix       <= '0;
      r_cnt       <= '0;
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_err       <= 1'b0;
      r_mul_start <= 1'b0;
      r_opr1      <= '0;
      r_opr2      <= '0;
      r_wo        <= 2'b00;
      r_wd        <= '0;
    end else begin
      r_rd_valid  <= 1'b0;
      r_mul_start <= 1'b0;
      r_wo        <= 2'b00;
      case (r_state)
        IDLE: if (bus.i_op_valid) begin
          case (bus.i_op_code)
            3'd1, 3'd2: begin
              r_opr1      <= w_abs_a;
              r_opr2      <= w_abs_b;
              r_neg       <= w_sgn && (bus.i_op_a[31] ^ bus.i_op_b[31]);
              r_mul_start <= 1'b1;
              r_state     <= ISSUE;
            end
            3'd3, 3'd4: begin
              r_rd_data  <= bus.i_op_code == 3'd3 ? bus.i_mul_result[63:32] : bus.i_mul_result[31:0];
              r_rd_valid <= 1'b1;
            end
            3'd5, 3'd6: begin
              r_wo    <= bus.i_op_code == 3'd5 ? 2'b10 : 2'b01;
              r_wd    <= bus.i_op_a;
              r_state <= WR;
            end
            default: ;
          endcase
        end
        ISSUE: begin
          r_cnt   <= '0;
          r_state <= WAIT;
        end
        WAIT: if (bus.i_mul_ready) begin
          if (r_neg) begin
            r_fix   <= w_neg_res;
            r_wo    <= 2'b01;
            r_wd    <= w_neg_res[31:0];
            r_state <= FIX_LO;
          end else begin
            r_state <= IDLE;
          end
        end else if (r_cnt == CW'(TIMEOUT - 1)) begin
          r_err   <= 1'b1;
          r_state <= IDLE;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        FIX_LO: begin
          r_wo    <= 2'b10;
          r_wd    <= r_fix[63:32];
          r_state <= FIX_HI;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_hilo_mul_ctrl.sv
// tb_hilo_mul_ctrl: directed checks of both SIGNED_EN builds against a behavioural HI/LO wrapper
module tb_hilo_mul_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic        sel = 1'b0;
  logic        valid = 1'b0;
  logic [2:0]  code = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        no_rdy = 1'b0;
  int checks = 0;
  int errors = 0;
  hilo_mul_ctrl_if b0 ();
  hilo_mul_ctrl_if b1 ();
  hilo_mul_ctrl #(.SIGNED_EN(1'b1), .TIMEOUT(63)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  hilo_mul_ctrl #(.SIGNED_EN(1'b0), .TIMEOUT(63)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  assign b0.i_op_valid = valid & ~sel;
  assign b1.i_op_valid = valid & sel;
  assign b0.i_op_code = code;
  assign b1.i_op_code = code;
  assign b0.i_op_a = a;
  assign b1.i_op_a = a;
  assign b0.i_op_b = b;
  assign b1.i_op_b = b;
  logic [63:0] hl[2] = '{64'd0, 64'd0};
  logic [63:0] pend[2] = '{64'd0, 64'd0};
  logic        rdy[2] = '{1'b0, 1'b0};
  logic        ps[2] = '{1'b0, 1'b0};
  int          cnt[2] = '{0, 0};
  logic        st[2];
  logic [31:0] o1[2], o2[2], wdm[2];
  logic [1:0]  wom[2];
  assign st[0] = b0.o_mul_start;
  assign st[1] = b1.o_mul_start;
  assign o1[0] = b0.o_mul_opr1;
  assign o1[1] = b1.o_mul_opr1;
  assign o2[0] = b0.o_mul_opr2;
  assign o2[1] = b1.o_mul_opr2;
  assign wom[0] = b0.o_mul_write_opt;
  assign wom[1] = b1.o_mul_write_opt;
  assign wdm[0] = b0.o_mul_write_data;
  assign wdm[1] = b1.o_mul_write_data;
  assign b0.i_mul_result = hl[0];
  assign b1.i_mul_result = hl[1];
  assign b0.i_mul_ready = rdy[0] & ~no_rdy;
  assign b1.i_mul_ready = rdy[1] & ~no_rdy;
  // wrapper model: rising start launches a 3-cycle unsigned multiply, write_opt updates LO/HI
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      ps[k] <= st[k];
      if (st[k] && !ps[k]) begin
        rdy[k]  <= 1'b0;
        cnt[k]  <= 3;
        pend[k] <= {32'd0, o1[k]} * {32'd0, o2[k]};
      end else if (cnt[k] != 0) begin
        cnt[k] <= cnt[k] - 1;
        if (cnt[k] == 1) begin
          hl[k]  <= pend[k];
          rdy[k] <= 1'b1;
        end
      end
      if (wom[k] == 2'b01) hl[k][31:0] <= wdm[k];
      else if (wom[k] == 2'b10) hl[k][63:32] <= wdm[k];
    end
  end
  logic        stall, rd_valid, err, mstart;
  logic [31:0] rd_data, opr1, opr2, wd;
  logic [1:0]  wo;
  assign stall    = sel ? b1.o_stall : b0.o_stall;
  assign rd_valid = sel ? b1.o_rd_valid : b0.o_rd_valid;
  assign err      = sel ? b1.o_err : b0.o_err;
  assign mstart   = sel ? b1.o_mul_start : b0.o_mul_start;
  assign rd_data  = sel ? b1.o_rd_data : b0.o_rd_data;
  assign opr1     = sel ? b1.o_mul_opr1 : b0.o_mul_opr1;
  assign opr2     = sel ? b1.o_mul_opr2 : b0.o_mul_opr2;
  assign wd       = sel ? b1.o_mul_write_data : b0.o_mul_write_data;
  assign wo       = sel ? b1.o_mul_write_opt : b0.o_mul_write_opt;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic op(input logic [2:0] c, input logic [31:0] x, input logic [31:0] y);
    valid = 1'b1;
    code = c;
    a = x;
    b = y;
    cyc();
    valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b expected 0", stall); end
    checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_rd_valid: got %b expected 0", rd_valid); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (mstart !== 1'b0) begin errors++; $display("FAIL reset_start: got %b expected 0", mstart); end
    checks++; if (wo !== 2'b00) begin errors++; $display("FAIL reset_write_opt: got %b expected 00", wo); end
    checks++; if ({opr1, opr2, rd_data, wd} !== 128'd0) begin errors++; $display("FAIL reset_data: got %h expected 0", {opr1, opr2, rd_data, wd}); end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_nop();
    sel = 1'b0;
    op(3'd0, 32'h1, 32'h2);
    checks++; if ({stall, mstart, rd_valid, wo} !== 5'd0) begin errors++; $display("FAIL nop: got %b expected 00000", {stall, mstart, rd_valid, wo}); end
    op(3'd7, 32'h1, 32'h2);
    checks++; if ({stall, mstart, rd_valid, wo} !== 5'd0) begin errors++; $display("FAIL reserved: got %b expected 00000", {stall, mstart, rd_valid, wo}); end
  endtask

  task automatic test_mult(input logic s, input logic [2:0] c, input logic [31:0] x, input logic [31:0] y,
                           input logic [31:0] e1, input logic [31:0] e2, input logic efix,
                           input logic [31:0] ehi, input logic [31:0] elo);
    int n = 0, lo_n = 0, hi_n = 0, starts = 0;
    logic [31:0] lo_d = 32'd0, hi_d = 32'd0;
    sel = s;
    op(c, x, y);
    checks++; if ({stall, mstart} !== 2'b11) begin errors++; $display("FAIL mult_issue %h*%h: got %b expected 11", x, y, {stall, mstart}); end
    checks++; if ({opr1, opr2} !== {e1, e2}) begin errors++; $display("FAIL mult_oprs %h*%h: got %h expected %h", x, y, {opr1, opr2}, {e1, e2}); end
    while (stall && n < 200) begin
      cyc();
      n++;
      if (mstart) starts++;
      if (wo == 2'b01) begin lo_n = n; lo_d = wd; end
      if (wo == 2'b10) begin hi_n = n; hi_d = wd; end
    end
    checks++; if (n !== (efix ? 7 : 5)) begin errors++; $display("FAIL mult_stall_len %h*%h: got %0d expected %0d", x, y, n, efix ? 7 : 5); end
    checks++; if (starts !== 0) begin errors++; $display("FAIL mult_start_pulse %h*%h: got %0d extra expected 0", x, y, starts); end
    checks++; if ({lo_n, hi_n} !== (efix ? {32'd5, 32'd6} : 64'd0)) begin errors++; $display("FAIL mult_fix_timing %h*%h: got lo@%0d hi@%0d", x, y, lo_n, hi_n); end
    checks++; if (efix && {hi_d, lo_d} !== {ehi, elo}) begin errors++; $display("FAIL mult_fix_data %h*%h: got %h expected %h", x, y, {hi_d, lo_d}, {ehi, elo}); end
    op(3'd3, 32'd0, 32'd0);
    checks++; if ({rd_valid, stall, rd_data} !== {2'b10, ehi}) begin errors++; $display("FAIL mfhi %h*%h: got %b %b %h expected 1 0 %h", x, y, rd_valid, stall, rd_data, ehi); end
    op(3'd4, 32'd0, 32'd0);
    checks++; if ({rd_valid, rd_data} !== {1'b1, elo}) begin errors++; $display("FAIL mflo %h*%h: got %b %h expected 1 %h", x, y, rd_valid, rd_data, elo); end
    cyc();
    checks++; if ({rd_valid, rd_data} !== {1'b0, elo}) begin errors++; $display("FAIL rd_hold %h*%h: got %b %h expected 0 %h", x, y, rd_valid, rd_data, elo); end
  endtask

  task automatic test_back_to_back(input logic [2:0] c, input logic [31:0] d, input logic [2:0] rc, input logic [1:0] ewo);
    sel = 1'b0;
    valid = 1'b1;
    code = c;
    a = d;
    cyc();
    checks++; if ({stall, wo, wd} !== {1'b1, ewo, d}) begin errors++; $display("FAIL mt_write op%0d: got %b %b %h expected 1 %b %h", c, stall, wo, wd, ewo, d); end
    code = rc;
    a = 32'd0;
    cyc();
    checks++; if ({stall, wo, rd_valid} !== 4'b0000) begin errors++; $display("FAIL mt_release op%0d: got %b %b %b expected 0 00 0", c, stall, wo, rd_valid); end
    cyc();
    valid = 1'b0;
    checks++; if ({rd_valid, rd_data} !== {1'b1, d}) begin errors++; $display("FAIL mf_after_mt op%0d: got %b %h expected 1 %h", c, rd_valid, rd_data, d); end
  endtask

  task automatic test_reset_mid();
    int writes = 0, stalls = 0;
    sel = 1'b0;
    op(3'd1, 32'hFFFFFFFD, 32'd5);
    cyc();
    cyc();
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rst_mid_wait: got %b expected 1", stall); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if ({stall, mstart, wo, opr1} !== 36'd0) begin errors++; $display("FAIL rst_mid_state: got %b %b %b %h expected all 0", stall, mstart, wo, opr1); end
    repeat (12) begin
      cyc();
      if (wo != 2'b00) writes++;
      if (stall) stalls++;
    end
    checks++; if ({writes, stalls} !== 64'd0) begin errors++; $display("FAIL rst_mid_quiet: got %0d writes %0d stalls expected 0 0", writes, stalls); end
  endtask

  task automatic test_timeout();
    int n = 0, early = 0;
    sel = 1'b0;
    no_rdy = 1'b1;
    op(3'd2, 32'd2, 32'd3);
    while (stall && n < 200) begin
      if (err) early++;
      cyc();
      n++;
    end
    checks++; if (n !== 64) begin errors++; $display("FAIL timeout_len: got %0d expected 64", n); end
    checks++; if ({err, early} !== {1'b1, 32'd0}) begin errors++; $display("FAIL timeout_err: got %b early %0d expected 1 early 0", err, early); end
    no_rdy = 1'b0;
    op(3'd3, 32'd0, 32'd0);
    checks++; if ({err, rd_valid} !== 2'b11) begin errors++; $display("FAIL err_sticky_mf: got %b expected 11", {err, rd_valid}); end
    op(3'd2, 32'd1, 32'd1);
    n = 0;
    while (stall && n < 200) begin cyc(); n++; end
    checks++; if ({err, stall} !== 2'b10) begin errors++; $display("FAIL err_sticky_mult: got %b expected 10", {err, stall}); end
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL err_reset: got %b expected 0", err); end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_mult(1'b0, 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h00000001);
    test_mult(1'b0, 3'd1, 32'hFFFFFFFD, 32'd5, 32'd3, 32'd5, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFF1);
    test_mult(1'b0, 3'd1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000);
    test_mult(1'b0, 3'd1, 32'd6, 32'hFFFFFFF9, 32'd6, 32'd7, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFD6);
    test_mult(1'b0, 3'd1, 32'hFFFFFFF9, 32'hFFFFFFFA, 32'd7, 32'd6, 1'b0, 32'h00000000, 32'h0000002A);
    test_mult(1'b1, 3'd1, 32'hFFFFFFFF, 32'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 32'h00000001, 32'hFFFFFFFE);
    test_mult(1'b1, 3'd1, 32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000, 1'b0, 32'h40000000, 32'h00000000);
    test_back_to_back(3'd5, 32'h12345678, 3'd3, 2'b10);
    test_back_to_back(3'd6, 32'hCAFEF00D, 3'd4, 2'b01);
    test_reset_mid();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
